// File: rtl/pool_stream.sv
// Streaming max pooler over WINDOW-sample windows with early close on in_last_i.
// Define POOL_AVG_EN to add a mode_i port and an averaging path (mode_i=1).
module pool_stream #(
    parameter int INTEGER_BITS     = 9,
    parameter int FIXED_POINT_BITS = 4,
    parameter int WINDOW           = 4,
    localparam int W = INTEGER_BITS + FIXED_POINT_BITS,
    localparam int L = $clog2(WINDOW)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    input  logic         in_last_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [L:0]   out_count_o
`ifdef POOL_AVG_EN
    ,
    input  logic         mode_i
`endif
);

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    localparam logic [L:0] WinCnt = (L + 1)'(WINDOW);

    state_e       state_q, state_d;
    logic [L:0]   count_q, count_d;
    logic [W-1:0] run_q, run_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [L:0]   out_count_q, out_count_d;

    logic         accept, first, close;
    logic [L:0]   cnt_inc;
    logic [W-1:0] max_val, result;

`ifdef POOL_AVG_EN
    logic                  mode_q, mode_d, mode_eff;
    logic signed [W+L-1:0] sum_q, sum_d, in_ext, sum_next, avg_full;

    assign mode_eff = first ? mode_i : mode_q;
    assign in_ext   = {{L{in_data_i[W-1]}}, in_data_i};
    assign sum_next = first ? in_ext : sum_q + in_ext;
    // Always divide by WINDOW, even for a partial window.
    assign avg_full = sum_next >>> L;
    assign result   = mode_eff ? avg_full[W-1:0] : max_val;
`else
    assign result = max_val;
`endif

    // In HOLD the slot frees up as the result leaves, giving zero-bubble streaming.
    assign in_ready_o  = rst_ni && ((state_q == StAccum) || out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign first       = (count_q == '0);
    assign cnt_inc     = count_q + 1'b1;
    assign max_val     = (first || ($signed(in_data_i) > $signed(run_q))) ? in_data_i : run_q;
    assign close       = accept && ((cnt_inc == WinCnt) || in_last_i);
    assign out_valid_o = (state_q == StHold);
    assign out_data_o  = out_data_q;
    assign out_count_o = out_count_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        run_d       = run_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
`ifdef POOL_AVG_EN
        sum_d       = sum_q;
        mode_d      = mode_q;
`endif
        if ((state_q == StHold) && out_ready_i) begin
            state_d = StAccum;
        end
        if (accept) begin
            run_d = max_val;
`ifdef POOL_AVG_EN
            sum_d  = sum_next;
            mode_d = mode_eff;
`endif
            if (close) begin
                out_data_d  = result;
                out_count_d = cnt_inc;
                count_d     = '0;
                state_d     = StHold;
            end else begin
                count_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StAccum;
            count_q     <= '0;
            run_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
`ifdef POOL_AVG_EN
            sum_q       <= '0;
            mode_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            run_q       <= run_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
`ifdef POOL_AVG_EN
            sum_q       <= sum_d;
            mode_q      <= mode_d;
`endif
        end
    end

endmodule

// File: tb/tb_pool_stream.sv
// Self-checking bench for pool_stream (WINDOW=4, 13-bit samples): vector table plus
// hand-written sequences for stall, zero-bubble, streaming and reset behaviour.
module tb_pool_stream;

    localparam int W = 13;
    localparam int L = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [L:0]   out_count;
    logic         mode;

    int checks;
    int failures;

    pool_stream #(
        .INTEGER_BITS     (9),
        .FIXED_POINT_BITS (4),
        .WINDOW           (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_count_o (out_count)
`ifdef POOL_AVG_EN
        ,
        .mode_i      (mode)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0][W-1:0] d;
        int                n;
        logic              last;
        logic              mode;
        logic [W-1:0]      exp_d;
        logic [L:0]        exp_c;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [W-1:0] d0, logic [W-1:0] d1, logic [W-1:0] d2,
                                logic [W-1:0] d3, int n, logic last, logic md,
                                logic [W-1:0] exp_d, logic [L:0] exp_c);
        vec_t v;
        v.d[0]  = d0;
        v.d[1]  = d1;
        v.d[2]  = d2;
        v.d[3]  = d3;
        v.n     = n;
        v.last  = last;
        v.mode  = md;
        v.exp_d = exp_d;
        v.exp_c = exp_c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    int results;

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        mode      = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        #20 rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        vecs.push_back(mk(13'h0010, 13'h1FF0, 13'h0030, 13'h0020, 4, 1'b0, 1'b0, 13'h0030, 3'd4));
        vecs.push_back(mk(13'h1FF0, 13'h1FE0, 13'h1000, 13'h1FC0, 4, 1'b0, 1'b0, 13'h1FF0, 3'd4));
        vecs.push_back(mk(13'h1000, 13'h1000, 13'h1000, 13'h1000, 4, 1'b0, 1'b0, 13'h1000, 3'd4));
        vecs.push_back(mk(13'h0040, 13'h0050, 13'h0000, 13'h0000, 2, 1'b1, 1'b0, 13'h0050, 3'd2));
        vecs.push_back(mk(13'h0005, 13'h0000, 13'h0000, 13'h0000, 1, 1'b1, 1'b0, 13'h0005, 3'd1));
        vecs.push_back(mk(13'h0FFF, 13'h1000, 13'h0000, 13'h0FFF, 4, 1'b0, 1'b0, 13'h0FFF, 3'd4));
        vecs.push_back(mk(13'h0001, 13'h0002, 13'h0003, 13'h0004, 4, 1'b1, 1'b0, 13'h0004, 3'd4));
        vecs.push_back(mk(13'h0001, 13'h0002, 13'h0003, 13'h0000, 3, 1'b1, 1'b0, 13'h0003, 3'd3));
        vecs.push_back(mk(13'h1001, 13'h1000, 13'h1002, 13'h0000, 3, 1'b1, 1'b0, 13'h1002, 3'd3));
`ifdef POOL_AVG_EN
        vecs.push_back(mk(13'h0010, 13'h0030, 13'h0020, 13'h0040, 4, 1'b0, 1'b1, 13'h0028, 3'd4));
        vecs.push_back(mk(13'h1FF0, 13'h0000, 13'h0000, 13'h0000, 4, 1'b0, 1'b1, 13'h1FFC, 3'd4));
        vecs.push_back(mk(13'h0010, 13'h0030, 13'h0000, 13'h0000, 2, 1'b1, 1'b1, 13'h0010, 3'd2));
`endif

        foreach (vecs[i]) begin
            mode = vecs[i].mode;
            for (int j = 0; j < vecs[i].n; j++) begin
                if (j == vecs[i].n - 1) check($sformatf("v%0d_pre_valid", i), 32'(out_valid), 32'd0);
                send(vecs[i].d[j], (j == vecs[i].n - 1) && vecs[i].last);
                if (j == 0) mode = ~vecs[i].mode;
            end
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].exp_d));
            check($sformatf("v%0d_count", i), 32'(out_count), 32'(vecs[i].exp_c));
            drain();
            check($sformatf("v%0d_drain", i), 32'(out_valid), 32'd0);
        end
        mode = 1'b0;

        // Stall in HOLD for 5 cycles, then zero-bubble handoff
        send(13'h0001, 1'b0);
        send(13'h0002, 1'b0);
        send(13'h0003, 1'b0);
        send(13'h0004, 1'b0);
        in_valid = 1'b1;
        in_data  = 13'h0100;
        for (int k = 0; k < 5; k++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'h0004);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("handoff_valid", 32'(out_valid), 32'd0);
        send(13'h0009, 1'b0);
        send(13'h0003, 1'b0);
        send(13'h0002, 1'b0);
        check("handoff_res_valid", 32'(out_valid), 32'd1);
        check("handoff_res_data", 32'(out_data), 32'h0100);
        check("handoff_res_count", 32'(out_count), 32'd4);
        drain();

        // One-sample window closed by in_last while the previous result leaves
        send(13'h0001, 1'b0);
        send(13'h0002, 1'b0);
        send(13'h0003, 1'b0);
        send(13'h0004, 1'b0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 13'h1F00;
        in_last   = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("rehold_valid", 32'(out_valid), 32'd1);
        check("rehold_data", 32'(out_data), 32'h1F00);
        check("rehold_count", 32'(out_count), 32'd1);
        tick();
        out_ready = 1'b0;
        check("rehold_drain", 32'(out_valid), 32'd0);

        // Continuous stream: one result every 4 cycles
        results   = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 13'(32'h20 + i);
            tick();
            check("stream_valid", 32'(out_valid), ((i + 1) % 4 == 0) ? 32'd1 : 32'd0);
            if (out_valid) begin
                check("stream_data", 32'(out_data), 32'h20 + 32'(4 * results + 3));
                results++;
            end
        end
        in_valid = 1'b0;
        check("stream_results", 32'(results), 32'd4);
        tick();
        out_ready = 1'b0;
        check("stream_drain", 32'(out_valid), 32'd0);

        // Reset while holding a result
        send(13'h0001, 1'b0);
        send(13'h0002, 1'b0);
        send(13'h0003, 1'b0);
        send(13'h0004, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("hold_rst_valid", 32'(out_valid), 32'd0);
        check("hold_rst_in_ready", 32'(in_ready), 32'd0);
        check("hold_rst_data", 32'(out_data), 32'd0);
        check("hold_rst_count", 32'(out_count), 32'd0);
        #2 rst_n = 1'b1;

        // Reset mid-window discards the partial accumulation
        send(13'h0F00, 1'b0);
        send(13'h0E00, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_no_result", 32'(out_valid), 32'd0);
        send(13'h0001, 1'b0);
        send(13'h0002, 1'b0);
        send(13'h0003, 1'b0);
        check("mid_rst_pre_valid", 32'(out_valid), 32'd0);
        send(13'h0004, 1'b0);
        check("mid_rst_valid_res", 32'(out_valid), 32'd1);
        check("mid_rst_data", 32'(out_data), 32'h0004);
        check("mid_rst_count", 32'(out_count), 32'd4);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pool_stream.md
POOL_STREAM -- requirements
Module: pool_stream

Interface
REQ-001 Parameter INTEGER_BITS, default 9, signed integer bits of each sample.
REQ-002 Parameter FIXED_POINT_BITS, default 4, fractional bits; W = INTEGER_BITS+FIXED_POINT_BITS.
REQ-003 Parameter WINDOW, default 4, samples per pooling window; power of two, 2..16; L = log2(WINDOW).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream sample valid.
REQ-007 in_ready  output  1  block accepts sample; transfer when in_valid && in_ready.
REQ-008 in_data  input  W  two's-complement fixed-point sample.
REQ-009 in_last  input  1  sample closes current window early (partial window).
REQ-010 out_valid  output  1  pooled result valid.
REQ-011 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-012 out_data  output  W  pooled result, same format as in_data.
REQ-013 out_count  output  L+1  number of samples that formed out_data (1..WINDOW).
REQ-014 mode  input  1  0 = max, 1 = average; present only with POOL_AVG_EN.

Function
REQ-015 Two-state FSM: ACCUM (collecting window) and HOLD (result held on output).
REQ-016 ACCUM: in_ready SHALL be 1; first accepted sample loads running value, each later sample updates it.
REQ-017 Max compare SHALL be signed two's-complement over all W bits; 13'h1000 is the most negative value, ties keep the stored value.
REQ-018 Window closes on the accepted sample that makes count == WINDOW or carries in_last=1, whichever first; in_last on the WINDOW-th sample closes one window only.
REQ-019 On close, out_data/out_count SHALL register the final result and FSM enters HOLD with out_valid=1 on the next cycle (latency 1 cycle after closing sample).
REQ-020 HOLD: out_data/out_count SHALL stay stable until transfer; in_ready = out_ready.
REQ-021 HOLD with out_ready=1: out_valid drops next cycle, FSM returns to ACCUM; a sample accepted in that same cycle SHALL be the first sample of the next window (zero-bubble throughput).
REQ-022 HOLD with out_ready=1 and that accepted sample closes a window (WINDOW... only via in_last): FSM stays HOLD with the new one-sample result, out_count=1.
REQ-023 in_valid=0 in ACCUM SHALL leave running value and count unchanged; no timeout.

Reset
REQ-024 rst_n low SHALL immediately force FSM=ACCUM, count=0, out_valid=0, out_data=0, out_count=0, running value=0.
REQ-025 Reset mid-window SHALL discard partial accumulation; no result is produced for it.
REQ-026 in_ready SHALL be 0 while rst_n is low and 1 on first clock after release.

Configuration
REQ-027 Macro POOL_AVG_EN defined: mode port exists; mode sampled on first sample of each window and held for that window.
REQ-028 Average mode: sign-extended sum in W+L bits, out_data = sum arithmetic-shifted right by L (floor), regardless of out_count.
REQ-029 POOL_AVG_EN undefined: no mode port, no adder/sum register, max pooling only.

Verification
REQ-030 WINDOW=4, samples 0x0010,0x1FF0,0x0030,0x0020, out_ready=1 -> out_valid one cycle after 4th, out_data=0x0030, out_count=4.
REQ-031 All-negative 0x1FF0,0x1FE0,0x1000,0x1FC0 -> out_data=0x1FF0; then 0x1000 x4 -> out_data=0x1000.
REQ-032 Samples 0x0040,0x0050 with in_last on 2nd -> out_data=0x0050, out_count=2; next window starts fresh.
REQ-033 out_ready=0 for 5 cycles in HOLD -> out_data stable, in_ready=0, no samples lost; continuous in_valid stream with out_ready=1 -> one result every 4 cycles.
REQ-034 rst_n pulsed low after 2 samples -> out_valid=0 immediately, next 4 samples 0x0001..0x0004 -> out_data=0x0004.
REQ-035 POOL_AVG_EN, mode=1, samples 0x0010,0x0030,0x0020,0x0040 -> out_data=0x0028; samples 0x1FF0,0x0000,0x0000,0x0000 -> out_data=0x1FFC.
